mic_frame_reader: RTL and testbench

- Drains the 16-bit, 128-deep mic sample buffer from its read side and repackages samples into fixed-length frames on a valid/ready stream toward the feature-extraction pipeline.
- Absorbs the buffer's registered one-cycle read latency with a 2-entry skid store, so it never over-reads and never drops a sample under back-pressure.
- Starts and stops only on frame boundaries.

---
 rtl/mic_pkg.sv | 14 +
 rtl/mic_skid2.sv | 50 +++++
 rtl/mic_frame_reader.sv | 102 ++++++++++
 tb/tb_mic_frame_reader.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mic_pkg.sv
// Shared constants and FSM encoding for the mic buffer read side.
package mic_pkg;

    localparam int SAMPLE_W          = 16;
    localparam int MICBUF_DEPTH      = 128;
    localparam int DEFAULT_FRAME_LEN = 256;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } mic_state_e;

endpackage

// File: rtl/mic_skid2.sv
// Two-entry in-order store that catches words returning from the buffer's
// registered read port. Entry e0 is always the head.
module mic_skid2 #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [1:0]   count
);

    logic [W-1:0] e0, e1;

    assign head = e0;

    // Shift-style storage: a pop moves e1 forward, a push lands behind the
    // last occupied entry (or straight into e0 when it is being vacated).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            e0    <= '0;
            e1    <= '0;
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) e0 <= din;
                    else               e1 <= din;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    e0    <= e1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        e0 <= din;
                    end else begin
                        e0 <= e1;
                        e1 <= din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/mic_frame_reader.sv
// Drains the mic sample buffer and re-emits samples as fixed-length frames
// with sof/eof markers. Start and stop happen only on frame boundaries.
module mic_frame_reader
    import mic_pkg::*;
#(
    parameter int DATA_W    = SAMPLE_W,
    parameter int FRAME_LEN = DEFAULT_FRAME_LEN,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_dout,
    input  logic              fifo_empty,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_sof,
    output logic              m_eof,
    output logic              busy,
    output logic [CNT_W-1:0]  frame_count
);

    localparam logic [1:0]       ST_IDLE  = IDLE;
    localparam logic [1:0]       ST_RUN   = RUN;
    localparam logic [1:0]       ST_STOP  = STOP;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    logic [1:0]       state, state_nxt;
    logic [CNT_W-1:0] issue_idx, emit_idx;
    logic             inflight;
    logic [1:0]       skid_cnt;
    logic             xfer;
    logic [2:0]       occ;

    // Every pop is captured the following cycle, whatever the sink is doing.
    mic_skid2 #(.W(DATA_W)) u_skid (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight),
        .din   (fifo_dout),
        .pop   (xfer),
        .head  (m_data),
        .count (skid_cnt)
    );

    assign m_valid = (skid_cnt != 2'd0);
    assign xfer    = m_valid & m_ready;
    assign busy    = (state != ST_IDLE);
    assign m_sof   = m_valid & (emit_idx == '0);
    assign m_eof   = m_valid & (emit_idx == LAST_IDX);

    // Slots committed after this edge: stored + returning - leaving now.
    // Counting the departing word keeps 1 sample/cycle without ever
    // needing a third slot.
    assign occ = {1'b0, skid_cnt} + {2'b00, inflight} - {2'b00, xfer};

    // A new frame may only be opened while enable is high; a frame in
    // progress keeps popping until its last sample is requested.
    assign fifo_rd_en = (state == ST_RUN) & ~fifo_empty
                      & (enable | (issue_idx != '0))
                      & (occ < 3'd2);

    // Next-state: IDLE -> RUN on enable, RUN stops only on a frame edge,
    // STOP waits for the last words to leave the store.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (enable) state_nxt = ST_RUN;
            ST_RUN: begin
                if (!enable && issue_idx == '0)
                    state_nxt = ST_IDLE;
                else if (!enable && fifo_rd_en && issue_idx == LAST_IDX)
                    state_nxt = ST_STOP;
            end
            ST_STOP: if (skid_cnt == 2'd0 && !inflight) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State, in-flight tracking and the pop/transfer position counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            inflight    <= 1'b0;
            issue_idx   <= '0;
            emit_idx    <= '0;
            frame_count <= '0;
        end else begin
            state    <= state_nxt;
            inflight <= fifo_rd_en;
            if (fifo_rd_en)
                issue_idx <= (issue_idx == LAST_IDX) ? '0 : issue_idx + 1'b1;
            if (xfer) begin
                emit_idx <= (emit_idx == LAST_IDX) ? '0 : emit_idx + 1'b1;
                if (emit_idx == LAST_IDX) frame_count <= frame_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mic_frame_reader.sv
// Bench for mic_frame_reader: a 256-sample build and a 2-sample / 2-bit
// counter build, each fed by a behavioural buffer with registered read data.
module tb_mic_frame_reader;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- build A: FRAME_LEN=256, CNT_W=16 ----------------
    logic        en_a = 1'b0, mr_a = 1'b0;
    logic        rd_a, emp_a, mv_a, sof_a, eof_a, busy_a;
    logic [15:0] dout_a = '0, data_a, fc_a;
    logic [15:0] mem_a [0:4095];
    int          wp_a = 0, rp_a = 0;

    assign emp_a = (wp_a == rp_a);
    always @(posedge clk) if (rd_a) begin
        dout_a <= mem_a[rp_a % 4096];
        rp_a   <= rp_a + 1;
    end

    mic_frame_reader #(.DATA_W(16), .FRAME_LEN(256), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .enable(en_a), .fifo_rd_en(rd_a),
        .fifo_dout(dout_a), .fifo_empty(emp_a), .m_data(data_a),
        .m_valid(mv_a), .m_ready(mr_a), .m_sof(sof_a), .m_eof(eof_a),
        .busy(busy_a), .frame_count(fc_a)
    );

    // ---------------- build B: FRAME_LEN=2, CNT_W=2 ----------------
    logic        en_b = 1'b0, mr_b = 1'b0;
    logic        rd_b, emp_b, mv_b, sof_b, eof_b, busy_b;
    logic [15:0] dout_b = '0, data_b;
    logic [1:0]  fc_b;
    logic [15:0] mem_b [0:63];
    int          wp_b = 0, rp_b = 0;

    assign emp_b = (wp_b == rp_b);
    always @(posedge clk) if (rd_b) begin
        dout_b <= mem_b[rp_b % 64];
        rp_b   <= rp_b + 1;
    end

    mic_frame_reader #(.DATA_W(16), .FRAME_LEN(2), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .enable(en_b), .fifo_rd_en(rd_b),
        .fifo_dout(dout_b), .fifo_empty(emp_b), .m_data(data_b),
        .m_valid(mv_b), .m_ready(mr_b), .m_sof(sof_b), .m_eof(eof_b),
        .busy(busy_b), .frame_count(fc_b)
    );

    // ---------------- observers (record accepted samples, protocol) ----------------
    logic [15:0] rxd_a[$], rxd_b[$];
    bit          rxs_a[$], rxe_a[$], rxs_b[$], rxe_b[$];
    int          xcyc_a[$];
    int          cyc = 0;
    int          pops_a = 0, xfers_a = 0, viol_a = 0, occv_a = 0;
    int          pops_b = 0, xfers_b = 0, viol_b = 0;
    bit          pv_a = 0, pr_a = 0, ps_a = 0, pe_a = 0;
    logic [15:0] pd_a = '0;

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            rxd_a.delete(); rxs_a.delete(); rxe_a.delete(); xcyc_a.delete();
            pops_a = 0; xfers_a = 0; pv_a = 0;
        end else begin
            if (pv_a && !pr_a && (!mv_a || data_a !== pd_a || sof_a !== ps_a || eof_a !== pe_a))
                viol_a++;
            if (rd_a && emp_a) viol_a++;
            if (rd_a) pops_a++;
            if (mv_a && mr_a) begin
                rxd_a.push_back(data_a); rxs_a.push_back(sof_a);
                rxe_a.push_back(eof_a); xcyc_a.push_back(cyc);
                xfers_a++;
            end
            if (pops_a - xfers_a > 2) occv_a++;
            pv_a = mv_a; pr_a = mr_a; pd_a = data_a; ps_a = sof_a; pe_a = eof_a;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            rxd_b.delete(); rxs_b.delete(); rxe_b.delete();
            pops_b = 0; xfers_b = 0;
        end else begin
            if (rd_b && emp_b) viol_b++;
            if (rd_b) pops_b++;
            if (mv_b && mr_b) begin
                rxd_b.push_back(data_b); rxs_b.push_back(sof_b); rxe_b.push_back(eof_b);
                xfers_b++;
            end
            if (pops_b - xfers_b > 2) viol_b++;
        end
    end

    // ---------------- reference model and stimulus helpers ----------------
    task automatic push_a(input int n, input logic [15:0] start);
        for (int i = 0; i < n; i++) begin
            mem_a[wp_a % 4096] = start + 16'(i);
            wp_a++;
        end
    endtask

    task automatic push_b(input int n, input logic [15:0] start);
        for (int i = 0; i < n; i++) begin
            mem_b[wp_b % 64] = start + 16'(i);
            wp_b++;
        end
    endtask

    task automatic wait_rx(input int sel, input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk); #1;
            if ((sel == 0 ? rxd_a.size() : rxd_b.size()) >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Stream index j (since reset) must carry ramp value start+k and
    // sof exactly at j%fl==0, eof exactly at j%fl==fl-1.
    function automatic int count_bad(input int sel, input int base, input int n,
                                     input logic [15:0] start, input int fl);
        int nb = 0;
        for (int k = 0; k < n; k++) begin
            int j = base + k;
            logic [15:0] d;
            bit s, e;
            if (j >= (sel == 0 ? rxd_a.size() : rxd_b.size())) begin
                nb++;
                continue;
            end
            d = (sel == 0) ? rxd_a[j] : rxd_b[j];
            s = (sel == 0) ? rxs_a[j] : rxs_b[j];
            e = (sel == 0) ? rxe_a[j] : rxe_b[j];
            if (d !== start + 16'(k) || s != (j % fl == 0) || e != (j % fl == fl - 1)) nb++;
        end
        return nb;
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset;
        #12;
        total++; if ({mv_a, rd_a, sof_a, eof_a, busy_a} !== 5'b0) begin bad++;
            $display("FAIL reset_ctl_a got=%b want=00000", {mv_a, rd_a, sof_a, eof_a, busy_a}); end
        total++; if (fc_a !== 16'd0) begin bad++; $display("FAIL reset_fc_a got=%0d want=0", fc_a); end
        total++; if (data_a !== 16'd0) begin bad++; $display("FAIL reset_data_a got=%h want=0", data_a); end
        total++; if ({mv_b, rd_b, busy_b, fc_b} !== 5'b0) begin bad++;
            $display("FAIL reset_b got=%b want=00000", {mv_b, rd_b, busy_b, fc_b}); end
        @(posedge clk); #1 rst = 1'b1;
    endtask

    task automatic test_basic;
        int fp = -1, fv = -1;
        bit ok;
        push_a(256, 16'h0001);
        @(posedge clk); #1;
        en_a = 1'b1; mr_a = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk); #1;
            if (rd_a && fp < 0) fp = c;
            if (mv_a && fv < 0) fv = c;
            if (rxd_a.size() >= 256) begin ok = 1'b1; break; end
        end
        total++; if (!ok) begin bad++; $display("FAIL basic_timeout got=%0d want=256", rxd_a.size()); end
        total++; if (fp !== 1) begin bad++; $display("FAIL basic_first_pop got=%0d want=1", fp); end
        // output comes from the store, so it trails the first pop by one or two cycles
        total++; if (fv - fp < 1 || fv - fp > 2) begin bad++;
            $display("FAIL basic_first_valid got=%0d want=1..2 after pop", fv - fp); end
        total++; if (count_bad(0, 0, 256, 16'h0001, 256) !== 0) begin bad++;
            $display("FAIL basic_stream got=%0d bad samples want=0", count_bad(0, 0, 256, 16'h0001, 256)); end
        total++; if (ok && xcyc_a[255] - xcyc_a[0] !== 255) begin bad++;
            $display("FAIL basic_b2b got=%0d cycles want=255", xcyc_a[255] - xcyc_a[0]); end
        @(posedge clk); #1;
        total++; if (fc_a !== 16'd1) begin bad++; $display("FAIL basic_fc got=%0d want=1", fc_a); end
    endtask

    task automatic test_random_ready;
        int base = rxd_a.size();
        bit ok = 1'b0;
        push_a(768, 16'h1000);
        for (int c = 0; c < 20000; c++) begin
            @(posedge clk); #1;
            mr_a = 1'($urandom_range(0, 1));
            if (rxd_a.size() >= base + 768) begin ok = 1'b1; break; end
        end
        mr_a = 1'b1;
        total++; if (!ok) begin bad++; $display("FAIL rand_timeout got=%0d want=%0d", rxd_a.size(), base + 768); end
        total++; if (count_bad(0, base, 768, 16'h1000, 256) !== 0) begin bad++;
            $display("FAIL rand_stream got=%0d bad samples want=0", count_bad(0, base, 768, 16'h1000, 256)); end
        total++; if (viol_a !== 0) begin bad++; $display("FAIL rand_protocol got=%0d violations want=0", viol_a); end
        total++; if (occv_a !== 0) begin bad++; $display("FAIL rand_occupancy got=%0d overruns want=0", occv_a); end
        @(posedge clk); #1;
        total++; if (fc_a !== 16'd4) begin bad++; $display("FAIL rand_fc got=%0d want=4", fc_a); end
    endtask

    task automatic test_gap;
        int base = rxd_a.size();
        int vhigh = 0;
        bit ok;
        push_a(100, 16'h2000);
        wait_rx(0, base + 100, 500, ok);
        total++; if (!ok) begin bad++; $display("FAIL gap_first_part got=%0d want=%0d", rxd_a.size(), base + 100); end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk); #1;
            if (mv_a) vhigh++;
        end
        total++; if (vhigh !== 0) begin bad++; $display("FAIL gap_valid got=%0d cycles high want=0", vhigh); end
        total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL gap_busy got=%b want=1", busy_a); end
        push_a(156, 16'h2000 + 16'd100);
        wait_rx(0, base + 256, 1000, ok);
        total++; if (!ok) begin bad++; $display("FAIL gap_second_part got=%0d want=%0d", rxd_a.size(), base + 256); end
        total++; if (ok && rxs_a[base + 100] !== 1'b0) begin bad++; $display("FAIL gap_no_sof got=%b want=0", rxs_a[base + 100]); end
        total++; if (count_bad(0, base, 256, 16'h2000, 256) !== 0) begin bad++;
            $display("FAIL gap_stream got=%0d bad samples want=0", count_bad(0, base, 256, 16'h2000, 256)); end
        @(posedge clk); #1;
        total++; if (fc_a !== 16'd5) begin bad++; $display("FAIL gap_fc got=%0d want=5", fc_a); end
    endtask

    task automatic test_enable_drop;
        int base = rxd_a.size();
        bit ok;
        push_a(768, 16'h3000);
        wait_rx(0, base + 266, 1000, ok);
        @(posedge clk); #1 en_a = 1'b0;
        wait_rx(0, base + 512, 1000, ok);
        total++; if (!ok) begin bad++; $display("FAIL drop_delivered got=%0d want=%0d", rxd_a.size(), base + 512); end
        repeat (30) @(posedge clk);
        #1;
        total++; if (rxd_a.size() !== base + 512) begin bad++;
            $display("FAIL drop_extra got=%0d want=%0d", rxd_a.size(), base + 512); end
        total++; if (wp_a - rp_a !== 256) begin bad++; $display("FAIL drop_pops_left got=%0d want=256", wp_a - rp_a); end
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL drop_busy got=%b want=0", busy_a); end
        total++; if (fc_a !== 16'd7) begin bad++; $display("FAIL drop_fc got=%0d want=7", fc_a); end
        total++; if (count_bad(0, base, 512, 16'h3000, 256) !== 0) begin bad++;
            $display("FAIL drop_stream got=%0d bad samples want=0", count_bad(0, base, 512, 16'h3000, 256)); end
    endtask

    task automatic test_reset_mid;
        int base = rxd_a.size();
        bit ok;
        en_a = 1'b1; mr_a = 1'b1;
        wait_rx(0, base + 50, 500, ok);
        @(posedge clk); #1 mr_a = 1'b0;
        @(negedge clk);
        total++; if (mv_a !== 1'b1) begin bad++; $display("FAIL rstmid_pre_valid got=%b want=1", mv_a); end
        #2 rst = 1'b0;
        #1;
        total++; if ({mv_a, rd_a, sof_a, eof_a, busy_a} !== 5'b0) begin bad++;
            $display("FAIL rstmid_ctl got=%b want=00000", {mv_a, rd_a, sof_a, eof_a, busy_a}); end
        total++; if (fc_a !== 16'd0 || data_a !== 16'd0) begin bad++;
            $display("FAIL rstmid_regs got=fc %0d data %h want=0 0", fc_a, data_a); end
        wp_a = rp_a;  // the buffer is cleared by the same reset
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        push_a(256, 16'h4000);
        mr_a = 1'b1;
        wait_rx(0, 256, 1000, ok);
        total++; if (!ok) begin bad++; $display("FAIL rstmid_timeout got=%0d want=256", rxd_a.size()); end
        total++; if (ok && (rxs_a[0] !== 1'b1 || rxd_a[0] !== 16'h4000)) begin bad++;
            $display("FAIL rstmid_first got=sof %b data %h want=1 4000", rxs_a[0], rxd_a[0]); end
        total++; if (count_bad(0, 0, 256, 16'h4000, 256) !== 0) begin bad++;
            $display("FAIL rstmid_stream got=%0d bad samples want=0", count_bad(0, 0, 256, 16'h4000, 256)); end
        @(posedge clk); #1;
        total++; if (fc_a !== 16'd1) begin bad++; $display("FAIL rstmid_fc got=%0d want=1", fc_a); end
    endtask

    task automatic test_small;
        bit ok;
        push_b(8, 16'h5000);
        @(posedge clk); #1;
        en_b = 1'b1; mr_b = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        total++; if (pops_b !== 2) begin bad++; $display("FAIL small_stall_pops got=%0d want=2", pops_b); end
        total++; if (mv_b !== 1'b1 || sof_b !== 1'b1 || data_b !== 16'h5000) begin bad++;
            $display("FAIL small_stall_head got=v%b sof%b %h want=v1 sof1 5000", mv_b, sof_b, data_b); end
        mr_b = 1'b1;
        wait_rx(1, 6, 200, ok);
        @(posedge clk); #1;
        total++; if (fc_b !== 2'd3) begin bad++; $display("FAIL small_fc3 got=%0d want=3", fc_b); end
        wait_rx(1, 8, 200, ok);
        total++; if (!ok) begin bad++; $display("FAIL small_timeout got=%0d want=8", rxd_b.size()); end
        repeat (3) @(posedge clk);
        #1;
        total++; if (fc_b !== 2'd0) begin bad++; $display("FAIL small_fc_wrap got=%0d want=0", fc_b); end
        total++; if (count_bad(1, 0, 8, 16'h5000, 2) !== 0) begin bad++;
            $display("FAIL small_stream got=%0d bad samples want=0", count_bad(1, 0, 8, 16'h5000, 2)); end
        total++; if (viol_b !== 0 || pops_b !== 8) begin bad++;
            $display("FAIL small_protocol got=viol %0d pops %0d want=0 8", viol_b, pops_b); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_random_ready();
        test_gap();
        test_enable_drop();
        test_reset_mid();
        test_small();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
